// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared constants and types for the dual-master SRAM arbiter.
//   ADDR_W      byte address width seen by both requesters
//   BANK_AW     word address width of one 512x8 macro
//   BANK_SEL_W  width of the bank-select field (addr[11:9])
//   req_id_t    identifies which requester owns an access
//   rd_pipe_t   one stage of the read-return pipeline
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ADDR_W     = 12;
    localparam int BANK_AW    = 9;
    localparam int BANK_SEL_W = 3;
    localparam int DATA_W     = 8;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // Read-return bookkeeping: the owner of the read and the bank whose Q
    // output must be steered back one cycle after the grant.
    typedef struct packed {
        logic                  valid;
        req_id_t               id;
        logic [BANK_SEL_W-1:0] bank;
    } rd_pipe_t;

    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:BANK_AW];
    endfunction

    function automatic logic [BANK_AW-1:0] word_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_AW-1:0];
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Purely combinational winner selection between CPU and DMA.
//   cpu_req, dma_req   live (reset-qualified) requests
//   cpu_quota_spent    CPU has used all of its consecutive grants while DMA
//                      was waiting
//   cpu_gnt, dma_gnt   one-hot-or-zero grant
//   any_gnt            some access is issued this cycle
//   winner             owner of the issued access (CPU when idle)
// -----------------------------------------------------------------------------
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    cpu_quota_spent,
    output logic    cpu_gnt,
    output logic    dma_gnt,
    output logic    any_gnt,
    output req_id_t winner
);

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        winner  = REQ_CPU;
        if (cpu_req && !(dma_req && cpu_quota_spent)) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
            winner  = REQ_DMA;
        end
        any_gnt = cpu_gnt | dma_gnt;
    end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates a CPU port and a DMA port onto NUM_BANKS shared 512x8 SRAM
// macros. The granted access drives the macro pins in the grant cycle; read
// data returns exactly one cycle later from the bank addressed at grant time.
// CPU has priority but may take at most CPU_WEIGHT consecutive grants while
// DMA is waiting.
//
// Ports
//   clk_i, rst_n                     clock, asynchronous active-low reset
//   cpu_/dma_ req, we, addr, wdata   request side (held until gnt)
//   cpu_/dma_ gnt                    access accepted this cycle (combinational)
//   cpu_/dma_ rvalid, rdata          read return, rdata is zero when !rvalid
//   CEN_all, WEN_all, A_all, D_all   shared macro controls (active-low)
//   GWEN                             per-bank active-low write enable
//   Q_all                            concatenated bank read data
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int CPU_WEIGHT = 4,
    parameter int NUM_BANKS  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_W-1:0]       cpu_rdata,

    input  logic                    dma_req,
    input  logic                    dma_we,
    input  logic [ADDR_W-1:0]       dma_addr,
    input  logic [DATA_W-1:0]       dma_wdata,
    output logic                    dma_gnt,
    output logic                    dma_rvalid,
    output logic [DATA_W-1:0]       dma_rdata,

    output logic                    CEN_all,
    output logic [DATA_W-1:0]       WEN_all,
    output logic [BANK_AW-1:0]      A_all,
    output logic [DATA_W-1:0]       D_all,
    output logic [NUM_BANKS-1:0]    GWEN,
    input  logic [8*NUM_BANKS-1:0]  Q_all
);

    localparam int                CNT_W   = $clog2(CPU_WEIGHT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CPU_WEIGHT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [BANK_AW-1:0] a_q,    a_d;
    logic [DATA_W-1:0]  d_q,    d_d;
    rd_pipe_t           rd_q,   rd_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Requests are qualified with rst_n so grants (and therefore every pin
    // that follows from a grant) drop immediately when reset asserts,
    // without waiting for a clock edge.
    logic    cpu_req_live;
    logic    dma_req_live;
    logic    cpu_quota_spent;
    logic    any_gnt;
    req_id_t winner;

    assign cpu_req_live    = cpu_req & rst_n;
    assign dma_req_live    = dma_req & rst_n;
    assign cpu_quota_spent = (cnt_q == CNT_MAX);

    sram_arb_pick u_pick (
        .cpu_req         (cpu_req_live),
        .dma_req         (dma_req_live),
        .cpu_quota_spent (cpu_quota_spent),
        .cpu_gnt         (cpu_gnt),
        .dma_gnt         (dma_gnt),
        .any_gnt         (any_gnt),
        .winner          (winner)
    );

    // ------------------------------------------------------------------
    // Winning access
    // ------------------------------------------------------------------
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic [BANK_SEL_W-1:0] sel_bank;

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == REQ_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
        wr_gnt   = any_gnt &  sel_we;
        rd_gnt   = any_gnt & ~sel_we;
        sel_bank = bank_of(sel_addr);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Consecutive CPU grant counter: only meaningful while DMA waits,
        // so it clears whenever DMA is idle or is served.
        cnt_d = cnt_q;
        if (!dma_req_live || dma_gnt) begin
            cnt_d = '0;
        end else if (cpu_gnt && !cpu_quota_spent) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A/D hold their last driven value when the bus is idle so the
        // macro inputs do not toggle needlessly.
        a_d = a_q;
        d_d = d_q;
        if (any_gnt) begin
            a_d = word_of(sel_addr);
        end
        if (wr_gnt) begin
            d_d = sel_wdata;
        end

        rd_d.valid = rd_gnt;
        rd_d.id    = winner;
        rd_d.bank  = sel_bank;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            a_q        <= '0;
            d_q        <= '0;
            rd_q.valid <= 1'b0;
            rd_q.id    <= REQ_CPU;
            rd_q.bank  <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            d_q   <= d_d;
            rd_q  <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM pins
    // ------------------------------------------------------------------
    always_comb begin
        CEN_all = ~any_gnt;
        WEN_all = wr_gnt ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
        A_all   = any_gnt ? word_of(sel_addr) : a_q;
        D_all   = wr_gnt ? sel_wdata : d_q;
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_gwen
        assign GWEN[gi] = ~(wr_gnt && (sel_bank == BANK_SEL_W'(gi)));
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] q_bank [NUM_BANKS];
    logic [DATA_W-1:0] rd_word;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_qsplit
        assign q_bank[gi] = Q_all[8*gi +: 8];
    end

    always_comb begin
        rd_word    = q_bank[rd_q.bank];
        cpu_rvalid = rd_q.valid && (rd_q.id == REQ_CPU);
        dma_rvalid = rd_q.valid && (rd_q.id == REQ_DMA);
        cpu_rdata  = cpu_rvalid ? rd_word : '0;
        dma_rdata  = dma_rvalid ? rd_word : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Drives sram_arbiter against a behavioural set of 512x8 macros. Expected
// values come from a flat 4 KiB byte-array model of the memory plus a simple
// "consecutive CPU wins while DMA waits" tally for arbitration.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int CPU_WEIGHT = 4;
    localparam int NUM_BANKS  = 8;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [11:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        CEN_all;
    logic [7:0]  WEN_all, D_all;
    logic [8:0]  A_all;
    logic [NUM_BANKS-1:0]   GWEN;
    logic [8*NUM_BANKS-1:0] Q_all;

    always #5 clk_i = ~clk_i;

    sram_arbiter #(.CPU_WEIGHT(CPU_WEIGHT), .NUM_BANKS(NUM_BANKS)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .CEN_all(CEN_all), .WEN_all(WEN_all), .A_all(A_all), .D_all(D_all),
        .GWEN(GWEN), .Q_all(Q_all)
    );

    // ------------------------------------------------------------------
    // Behavioural SRAM macros
    // ------------------------------------------------------------------
    logic [7:0] ref_mem  [4096];
    logic [7:0] sram_mem [NUM_BANKS][512];
    logic [7:0] sram_q   [NUM_BANKS];
    logic       preload_go = 1'b0;

    always @(posedge clk_i) begin
        if (preload_go) begin
            for (int i = 0; i < 4096; i++) begin
                logic [11:0] ia;
                ia = 12'(i);
                sram_mem[ia[11:9]][ia[8:0]] <= ref_mem[i];
            end
        end else if (!CEN_all) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (!GWEN[b])
                    sram_mem[b][A_all] <= (sram_mem[b][A_all] & WEN_all) | (D_all & ~WEN_all);
                else
                    sram_q[b] <= sram_mem[b][A_all];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_q
        assign Q_all[8*gi +: 8] = sram_q[gi];
    end

    // ------------------------------------------------------------------
    // Reference model state and checking
    // ------------------------------------------------------------------
    int         tests = 0;
    int         fails = 0;
    int         streak;
    logic [8:0] last_a;
    logic [7:0] last_d;
    bit         pend_v;
    bit         pend_dma;
    logic [7:0] pend_data;
    string      dut_seq;
    int         dma_gnt_count;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
        check({pfx, "_dma_gnt"},    32'(dma_gnt),    32'd0);
        check({pfx, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check({pfx, "_dma_rvalid"}, 32'(dma_rvalid), 32'd0);
        check({pfx, "_cpu_rdata"},  32'(cpu_rdata),  32'd0);
        check({pfx, "_dma_rdata"},  32'(dma_rdata),  32'd0);
        check({pfx, "_CEN"},        32'(CEN_all),    32'd1);
        check({pfx, "_GWEN"},       32'(GWEN),       32'hFF);
        check({pfx, "_WEN"},        32'(WEN_all),    32'hFF);
        check({pfx, "_A"},          32'(A_all),      32'd0);
        check({pfx, "_D"},          32'(D_all),      32'd0);
    endtask

    task automatic model_reset();
        streak = 0;
        last_a = '0;
        last_d = '0;
        pend_v = 1'b0;
    endtask

    // One bus cycle: drive at posedge+1, check at negedge, return the
    // model's expected grants and leave time at the next posedge+1.
    task automatic do_cycle(input bit cr, input bit cw, input logic [11:0] ca, input logic [7:0] cd,
                            input bit dr, input bit dw, input logic [11:0] da, input logic [7:0] dd,
                            output bit gc, output bit gd);
        bit          ec, ed, we;
        logic [11:0] addr;
        logic [7:0]  wd;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk_i);
        cyc++;
        ec   = cr && !(dr && streak == CPU_WEIGHT);
        ed   = dr && !ec;
        we   = ec ? cw : dw;
        addr = ec ? ca : da;
        wd   = ec ? cd : dd;

        check("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        check("dma_gnt", 32'(dma_gnt), 32'(ed));
        check("CEN", 32'(CEN_all), 32'(!(ec || ed)));
        if (ec || ed) begin
            check("A", 32'(A_all), 32'(addr[8:0]));
            if (we) begin
                check("GWEN_wr", 32'(GWEN), 32'(8'(~(8'd1 << addr[11:9]))));
                check("WEN_wr", 32'(WEN_all), 32'h00);
                check("D_wr", 32'(D_all), 32'(wd));
            end else begin
                check("GWEN_rd", 32'(GWEN), 32'hFF);
            end
        end else begin
            check("GWEN_idle", 32'(GWEN), 32'hFF);
            check("WEN_idle", 32'(WEN_all), 32'hFF);
            check("A_hold", 32'(A_all), 32'(last_a));
            check("D_hold", 32'(D_all), 32'(last_d));
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend_v && !pend_dma));
        check("dma_rvalid", 32'(dma_rvalid), 32'(pend_v && pend_dma));
        check("cpu_rdata", 32'(cpu_rdata), (pend_v && !pend_dma) ? 32'(pend_data) : 32'd0);
        check("dma_rdata", 32'(dma_rdata), (pend_v && pend_dma) ? 32'(pend_data) : 32'd0);

        $display("[TB] cyc %0d cpu(r%0d w%0d %h) dma(r%0d w%0d %h) exp_gnt C%0d D%0d got C%0d D%0d",
                 cyc, cr, cw, ca, dr, dw, da, ec, ed, cpu_gnt, dma_gnt);
        dut_seq = {dut_seq, cpu_gnt ? "C" : (dma_gnt ? "D" : "-")};
        if (dma_gnt) dma_gnt_count++;

        pend_v = 1'b0;
        if (ec || ed) begin
            last_a = addr[8:0];
            if (we) begin
                last_d        = wd;
                ref_mem[addr] = wd;
            end else begin
                pend_v    = 1'b1;
                pend_dma  = ed;
                pend_data = ref_mem[addr];
            end
        end
        if (!dr || ed)
            streak = 0;
        else if (ec && streak < CPU_WEIGHT)
            streak++;

        gc = ec;
        gd = ed;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        bit gc, gd;
        for (int k = 0; k < n; k++)
            do_cycle(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, gc, gd);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit          gc, gd;
        bit          c_p, c_we, d_p, d_we;
        logic [11:0] c_a, d_a;
        logic [7:0]  c_d, d_d;
        logic [11:0] hot [4];

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        model_reset();
        dut_seq = "";
        dma_gnt_count = 0;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        ref_mem[12'h5A3] = 8'h3C;

        // Reset values are visible before any clock edge
        #2;
        check_reset_vals("por");

        preload_go = 1'b1;
        @(posedge clk_i);
        #1;
        preload_go = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;

        // CPU read straight out of reset; bank 2 word 1A3 holds 3C
        do_cycle(1, 0, 12'h5A3, 8'h00, 0, 0, 12'h0, 8'h0, gc, gd);
        idle(1);

        // DMA write then read of the same address (bank 7)
        do_cycle(0, 0, 12'h0, 8'h0, 1, 1, 12'hE10, 8'hA5, gc, gd);
        do_cycle(0, 0, 12'h0, 8'h0, 1, 0, 12'hE10, 8'h00, gc, gd);
        idle(1);

        // Idle stretch
        idle(5);

        // Both requesting continuously
        dut_seq = "";
        for (int k = 0; k < 10; k++)
            do_cycle(1, 0, 12'(k * 37), 8'h0, 1, 0, 12'h123, 8'h0, gc, gd);
        check("weighted_seq", 32'(dut_seq == "CCCCDCCCCD"), 32'd1);
        idle(1);

        // DMA alone for 10 cycles
        dma_gnt_count = 0;
        for (int k = 0; k < 10; k++)
            do_cycle(0, 0, 12'h0, 8'h0, 1, 0, 12'(k * 113), 8'h0, gc, gd);
        check("dma_alone_gnts", 32'(dma_gnt_count), 32'd10);
        idle(1);

        // Reset during a read return
        do_cycle(1, 0, 12'h2B7, 8'h0, 0, 0, 12'h0, 8'h0, gc, gd);
        cpu_req = 1; dma_req = 1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_a");
        @(posedge clk_i);
        #1;
        check_reset_vals("rst_b");
        rst_n = 1'b1;
        model_reset();
        do_cycle(1, 0, 12'h044, 8'h0, 0, 0, 12'h0, 8'h0, gc, gd);
        check("post_reset_gnt", 32'(gc), 32'd1);
        idle(1);

        // Randomized traffic with a few hot addresses for read-after-write
        for (int h = 0; h < 4; h++) hot[h] = 12'($urandom);
        c_p = 0; d_p = 0;
        c_we = 0; d_we = 0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
        for (int k = 0; k < 400; k++) begin
            if (!c_p && $urandom_range(0, 99) < 60) begin
                c_p  = 1;
                c_we = 1'($urandom_range(0, 1));
                c_a  = ($urandom_range(0, 2) == 0) ? hot[$urandom_range(0, 3)] : 12'($urandom);
                c_d  = 8'($urandom);
            end
            if (!d_p && $urandom_range(0, 99) < 55) begin
                d_p  = 1;
                d_we = 1'($urandom_range(0, 1));
                d_a  = ($urandom_range(0, 2) == 0) ? hot[$urandom_range(0, 3)] : 12'($urandom);
                d_d  = 8'($urandom);
            end
            do_cycle(c_p, c_we, c_a, c_d, d_p, d_we, d_a, d_d, gc, gd);
            if (gc) c_p = 0;
            if (gd) d_p = 0;
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter CPU_WEIGHT, default 4: maximum consecutive CPU grants while DMA is also requesting.
REQ-002 SHALL have parameter NUM_BANKS, default 8: number of 512x8 SRAM macros.
REQ-003 clk_i  input  1  single clock; all SRAM macros share this clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cpu_req/dma_req  input  1  access request, held until granted.
REQ-006 cpu_we/dma_we  input  1  1 = write, 0 = read; held with req.
REQ-007 cpu_addr/dma_addr  input  12  byte address; [11:9] selects bank, [8:0] selects word.
REQ-008 cpu_wdata/dma_wdata  input  8  write data.
REQ-009 cpu_gnt/dma_gnt  output  1  access accepted this cycle.
REQ-010 cpu_rvalid/dma_rvalid  output  1  read data valid.
REQ-011 cpu_rdata/dma_rdata  output  8  read data.
REQ-012 CEN_all  output  1  active-low chip enable, shared by all banks.
REQ-013 WEN_all  output  8  active-low bit write mask.
REQ-014 A_all  output  9  word address.
REQ-015 D_all  output  8  write data.
REQ-016 GWEN  output  NUM_BANKS  active-low per-bank write enable.
REQ-017 Q_all  input  8*NUM_BANKS  bank read data; bank n occupies [8n+7:8n].

Function
REQ-018 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, and the granted access drives the SRAM pins in the same cycle.
REQ-019 With a single requester active, that requester SHALL be granted every cycle; back-to-back grants are allowed.
REQ-020 When both request, CPU SHALL win unless the consecutive-CPU-grant counter equals CPU_WEIGHT; in that case DMA wins.
REQ-021 The counter SHALL increment on each CPU grant made while dma_req=1, saturating at CPU_WEIGHT, and SHALL clear on any DMA grant or any cycle with dma_req=0.
REQ-022 With no grant: CEN_all=1, GWEN all 1, WEN_all=8'hFF, A_all and D_all hold their previous values.
REQ-023 Granted read: CEN_all=0, GWEN all 1, A_all=addr[8:0].
REQ-024 Granted write: CEN_all=0, GWEN[addr[11:9]]=0 with all other GWEN bits 1, WEN_all=8'h00, D_all=wdata.
REQ-025 Read latency SHALL be exactly 1 cycle: rvalid is asserted the cycle after gnt, and rdata = Q_all slice selected by the registered bank index.
REQ-026 rvalid SHALL be a single-cycle pulse per granted read; writes produce no rvalid.
REQ-027 rdata SHALL be 8'h00 whenever rvalid=0.
REQ-028 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-029 A requester may be granted a new access in the same cycle its previous rvalid is asserted.

Reset
REQ-030 On rst_n=0, without waiting for a clock edge: gnt=0, rvalid=0, rdata=0, CEN_all=1, GWEN all 1, WEN_all=8'hFF, A_all=0, D_all=0, counter=0.
REQ-031 A read in flight when reset asserts SHALL be dropped; no rvalid after reset release.
REQ-032 The first cycle after reset release SHALL accept requests normally.

Structure
REQ-033 Package sram_arb_pkg SHALL hold ADDR_W=12, BANK_AW=9, BANK_SEL_W=3, and enum req_id_t {REQ_CPU, REQ_DMA}.
REQ-034 The read-return pipeline SHALL be registered: a valid bit, a req_id_t and a bank index.
REQ-035 One optional combinational sub-module, sram_arb_pick (winner selection); no other hierarchy.

Verification
REQ-036 CPU read 12'h5A3 alone, bank 2 preloaded 8'h3C at word 9'h1A3 -> cpu_gnt at cycle 0; GWEN=8'hFF, A_all=9'h1A3; cpu_rvalid=1 with cpu_rdata=8'h3C at cycle 1.
REQ-037 DMA write 12'hE10 data 8'hA5, then DMA read 12'hE10 next cycle -> GWEN=8'h7F, WEN_all=8'h00 on the write; dma_rdata=8'hA5 one cycle after the read grant.
REQ-038 Both requesting continuously, CPU_WEIGHT=4 -> grant sequence C,C,C,C,D,C,C,C,C,D.
REQ-039 dma_req held alone for 10 cycles -> 10 consecutive dma_gnt and no CEN_all gaps.
REQ-040 rst_n pulsed low the cycle after a CPU read grant -> no cpu_rvalid; all outputs at REQ-030 values during reset; a CPU request immediately after release is granted.
REQ-041 Idle for 5 cycles -> CEN_all=1 and no gnt or rvalid asserted.
